// File: rtl/cafeteira_agendador.sv
// rtl/cafeteira_agendador.sv - round-robin brew order scheduler with FIFO, watchdog and cool-down
//
// Purpose: takes brew orders from the front panel and the serial link and
// queues them in a small FIFO. It dispatches one order at a time to the brew
// controller and reports the result tagged with the order's origin. After a
// successful brew it holds off for a cool-down pause.
//
// Optional feature: define AGENDADOR_FLUSH_ERRO_EN to empty the queue whenever
// an order fails (entering FALHA). A push in that same cycle is discarded.
//
// Parameters:
//   PROFUNDIDADE  FIFO depth in orders (power of 2, >= 2)
//   T_LIMITE      watchdog cycles allowed in AGUARDA before a forced failure
//   T_PAUSA       cool-down cycles after a successful brew
//
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   req_painel, modo_painel   panel request (held until ack) and cup mode
//   ack_painel                one-cycle pulse: panel order enqueued
//   req_serial, modo_serial   serial request (held until ack) and cup mode
//   ack_serial                one-cycle pulse: serial order enqueued
//   cancelar                  flush pending orders; the running brew continues
//   preparar, modo            start pulse and held mode to the brew controller
//   fim_preparo, erro_preparo brew-controller success / error pulses
//   pedido_ok, pedido_erro    one-cycle result pulses
//   origem                    origin of running/reported order (0 panel, 1 serial)
//   ocupado                   high in every state except OCIOSO
//   fila_vazia, fila_cheia    FIFO empty / full
//   ocupacao                  number of queued orders
//   db_estado                 current state code
module cafeteira_agendador #(
  parameter int PROFUNDIDADE = 4,
  parameter int T_LIMITE     = 100_000_000,
  parameter int T_PAUSA      = 1_000
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            req_painel,
  input  logic [1:0]                      modo_painel,
  output logic                            ack_painel,
  input  logic                            req_serial,
  input  logic [1:0]                      modo_serial,
  output logic                            ack_serial,
  input  logic                            cancelar,
  output logic                            preparar,
  output logic [1:0]                      modo,
  input  logic                            fim_preparo,
  input  logic                            erro_preparo,
  output logic                            pedido_ok,
  output logic                            pedido_erro,
  output logic                            origem,
  output logic                            ocupado,
  output logic                            fila_vazia,
  output logic                            fila_cheia,
  output logic [$clog2(PROFUNDIDADE):0]   ocupacao,
  output logic [2:0]                      db_estado
);

  localparam int PW    = $clog2(PROFUNDIDADE);
  localparam int OW    = PW + 1;
  localparam int T_MAX = (T_LIMITE > T_PAUSA) ? T_LIMITE : T_PAUSA;
  localparam int CW    = $clog2(T_MAX) + 1;

  localparam logic [CW-1:0] LIMITE_FIM = CW'(T_LIMITE - 1);
  localparam logic [CW-1:0] PAUSA_FIM  = CW'(T_PAUSA - 1);
  localparam logic [OW-1:0] CAPACIDADE = OW'(PROFUNDIDADE);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    DISPARA = 3'd1,
    AGUARDA = 3'd2,
    CONCLUI = 3'd3,
    FALHA   = 3'd4,
    PAUSA   = 3'd5
  } estado_t;

  estado_t          estado;
  estado_t          estado_prox;
  logic [CW-1:0]    contador;

  // FIFO entry is {origem, modo}
  logic [2:0]       fila_mem [PROFUNDIDADE];
  logic [PW-1:0]    ptr_esc;
  logic [PW-1:0]    ptr_lei;
  logic [OW-1:0]    contagem;

  logic             prio_serial;
  logic             ack_painel_q;
  logic             ack_serial_q;
  logic [1:0]       modo_q;
  logic             origem_q;

  logic             cheia;
  logic             vazia;
  logic             esvaziar;
  logic             eleg_painel;
  logic             eleg_serial;
  logic             grant_painel;
  logic             grant_serial;
  logic             push;
  logic             pop;
  logic [2:0]       entrada;

  assign cheia = (contagem == CAPACIDADE);
  assign vazia = (contagem == '0);

`ifdef AGENDADOR_FLUSH_ERRO_EN
  // A failing order invalidates everything queued behind it.
  assign esvaziar = cancelar || (estado_prox == FALHA);
`else
  assign esvaziar = cancelar;
`endif

  // The ack term blocks a second push while the requester still holds req
  // during its own ack cycle.
  assign eleg_painel  = req_painel && !ack_painel_q && !cheia && !esvaziar;
  assign eleg_serial  = req_serial && !ack_serial_q && !cheia && !esvaziar;
  assign grant_painel = eleg_painel && (!eleg_serial || !prio_serial);
  assign grant_serial = eleg_serial && (!eleg_painel ||  prio_serial);
  assign push         = grant_painel || grant_serial;
  assign entrada      = grant_serial ? {1'b1, modo_serial} : {1'b0, modo_painel};
  assign pop          = (estado == DISPARA);

  always_ff @(posedge clock) begin
    if (push) begin
      fila_mem[ptr_esc] <= entrada;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_esc      <= '0;
      ptr_lei      <= '0;
      contagem     <= '0;
      prio_serial  <= 1'b0;
      ack_painel_q <= 1'b0;
      ack_serial_q <= 1'b0;
    end else begin
      ack_painel_q <= grant_painel;
      ack_serial_q <= grant_serial;
      if (push) begin
        prio_serial <= !prio_serial;
      end
      if (esvaziar) begin
        ptr_esc  <= '0;
        ptr_lei  <= '0;
        contagem <= '0;
      end else begin
        if (push) begin
          ptr_esc <= ptr_esc + 1'b1;
        end
        if (pop) begin
          ptr_lei <= ptr_lei + 1'b1;
        end
        case ({push, pop})
          2'b10:   contagem <= contagem + 1'b1;
          2'b01:   contagem <= contagem - 1'b1;
          default: contagem <= contagem;
        endcase
      end
    end
  end

  // Once DISPARA is entered the order is committed; a cancel arriving in the
  // DISPARA cycle only flushes what is still queued behind it.
  always_comb begin
    estado_prox = estado;
    case (estado)
      OCIOSO: begin
        if (!vazia && !cancelar) begin
          estado_prox = DISPARA;
        end
      end
      DISPARA: estado_prox = AGUARDA;
      AGUARDA: begin
        if (erro_preparo || (contador == LIMITE_FIM)) begin
          estado_prox = FALHA;
        end else if (fim_preparo) begin
          estado_prox = CONCLUI;
        end
      end
      CONCLUI: estado_prox = PAUSA;
      FALHA:   estado_prox = OCIOSO;
      PAUSA: begin
        if (contador == PAUSA_FIM) begin
          estado_prox = OCIOSO;
        end
      end
      default: estado_prox = OCIOSO;
    endcase
  end

  // contador restarts on every state change, so it holds the number of
  // cycles already spent in the current state.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= OCIOSO;
      contador <= '0;
      modo_q   <= 2'b00;
      origem_q <= 1'b0;
    end else begin
      estado <= estado_prox;
      if (estado_prox != estado) begin
        contador <= '0;
      end else if ((estado == AGUARDA) || (estado == PAUSA)) begin
        contador <= contador + 1'b1;
      end
      // Latch on the edge into DISPARA so modo is already valid with preparar.
      if ((estado == OCIOSO) && (estado_prox == DISPARA)) begin
        {origem_q, modo_q} <= fila_mem[ptr_lei];
      end
    end
  end

  assign ack_painel  = ack_painel_q;
  assign ack_serial  = ack_serial_q;
  assign preparar    = (estado == DISPARA);
  assign modo        = modo_q;
  assign origem      = origem_q;
  assign pedido_ok   = (estado == CONCLUI);
  assign pedido_erro = (estado == FALHA);
  assign ocupado     = (estado != OCIOSO);
  assign fila_vazia  = vazia;
  assign fila_cheia  = cheia;
  assign ocupacao    = contagem;
  assign db_estado   = estado;

endmodule

// File: doc/cafeteira_agendador.md
# cafeteira_agendador

Order scheduler in front of the coffee-maker control unit. Accepts brew orders from two requesters (front panel and serial link), arbitrates them round-robin into a small FIFO, and dispatches one order at a time to the brew controller through a `preparar` pulse plus a held `modo`. It waits for success or error, reports the result back tagged with the order's origin, and enforces a cool-down pause between brews.

## Interface
Parameters:
- PROFUNDIDADE, 4, FIFO depth in orders; must be a power of 2, at least 2.
- T_LIMITE, 100_000_000, watchdog cycles allowed in AGUARDA before a forced failure.
- T_PAUSA, 1_000, cool-down cycles after a successful brew.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- req_painel  in  1  panel order request; held until `ack_painel`.
- modo_painel  in  2  panel cup-size mode.
- ack_painel  out  1  one-cycle pulse: panel order enqueued.
- req_serial  in  1  serial order request; held until `ack_serial`.
- modo_serial  in  2  serial cup-size mode.
- ack_serial  out  1  one-cycle pulse: serial order enqueued.
- cancelar  in  1  flushes pending orders; never aborts the running brew.
- preparar  out  1  one-cycle start pulse to the brew controller.
- modo  out  2  mode of the running order.
- fim_preparo  in  1  brew-controller success pulse.
- erro_preparo  in  1  brew-controller error pulse (water, cup or boiler).
- pedido_ok  out  1  one-cycle pulse: order finished successfully.
- pedido_erro  out  1  one-cycle pulse: order failed.
- origem  out  1  origin of the running or just-reported order; 0 = panel, 1 = serial.
- ocupado  out  1  high in every state except OCIOSO.
- fila_vazia  out  1  FIFO empty.
- fila_cheia  out  1  FIFO full.
- ocupacao  out  clog2(PROFUNDIDADE)+1  number of queued orders.
- db_estado  out  3  current state code.

## Operation
- FIFO entry = {origem, modo} (3 bits). Pointers wrap modulo PROFUNDIDADE.
- Acceptance, evaluated each cycle:
  - A requester is eligible when its req=1, its ack is currently 0, the FIFO is not full and cancelar=0.
  - At most one push per cycle. If both are eligible, the requester holding priority wins.
  - After reset, priority is panel. Priority flips to the other requester after every accepted push.
  - The loser stays pending and holds req.
- Full check uses the current occupancy; a simultaneous pop does not free a slot in the same cycle.
- A push and a pop in the same cycle leave ocupacao unchanged.
- cancelar=1 empties the FIFO on the next edge and has priority over any push or pop in that cycle. That cycle produces no ack and no dispatch.
- State machine (db_estado codes):
  - OCIOSO (0): if the FIFO is not empty and cancelar=0, go to DISPARA.
  - DISPARA (1): pop the head; latch modo/origem; preparar=1; go to AGUARDA.
  - AGUARDA (2): watchdog counts. On erro_preparo, or watchdog reaching T_LIMITE-1, go to FALHA. Else on fim_preparo, go to CONCLUI. If both pulses arrive in the same cycle, erro wins.
  - CONCLUI (3): pedido_ok=1; go to PAUSA.
  - FALHA (4): pedido_erro=1; go to OCIOSO.
  - PAUSA (5): counts T_PAUSA cycles, then goes to OCIOSO.
- Illegal state codes go to OCIOSO.
- modo and origem hold their latched values from DISPARA until the next DISPARA.
- fim_preparo and erro_preparo are ignored outside AGUARDA.

## Timing
- Reset (synchronous): state OCIOSO, FIFO empty, priority panel, counters 0. All outputs 0 except fila_vazia=1.
- Acceptance at edge N (evaluated in cycle N-1): ack high during cycle N only, and ocupacao updated in cycle N.
- Idle, empty-queue latency:
  - DISPARA and preparar during cycle N+1.
  - AGUARDA from N+2.
- fim_preparo sampled in cycle M: pedido_ok in cycle M+1, then PAUSA for T_PAUSA cycles, then OCIOSO.
- Earliest next preparar: M+T_PAUSA+3.
- erro_preparo sampled in cycle M: pedido_erro in cycle M+1, then OCIOSO at M+2.
- Watchdog: FALHA is entered after exactly T_LIMITE cycles in AGUARDA with no pulse.
- Reset asserted mid-brew: the order is lost silently; no pedido_ok or pedido_erro is issued.

## Configuration
- AGENDADOR_FLUSH_ERRO_EN defined: entering FALHA also empties the FIFO, with the same effect as cancelar.
  - Rationale: a water or cup fault invalidates the queued orders.
  - A push in that same cycle is discarded (no ack).
- Macro undefined: FIFO contents survive FALHA, and the next order dispatches from OCIOSO normally.

## Test plan
- Reset, then panel req with modo=2 -> ack_painel at edge 1, preparar with modo=2 and origem=0 at cycle 2, fim_preparo pulse -> pedido_ok=1 with origem=0, then db_estado=5 for T_PAUSA cycles.
- Both reqs held in the same cycle while busy -> panel acked first, serial acked next cycle; queue order panel, serial; the next simultaneous pair is won by panel again.
- Fill to PROFUNDIDADE=4 -> fila_cheia=1, a fifth req receives no ack until a pop; cancelar then gives ocupacao=0 while the running brew still completes with pedido_ok.
- Two orders queued, erro_preparo on the first -> pedido_erro=1; with AGENDADOR_FLUSH_ERRO_EN, fila_vazia=1 and no further preparar; without it, the second preparar follows 2 cycles later.
- No pulse in AGUARDA with T_LIMITE=16 -> pedido_erro exactly 17 cycles after the DISPARA cycle; fim_preparo and erro_preparo together -> pedido_erro only.
- Reset mid-AGUARDA with 3 orders queued -> next cycle db_estado=0, ocupacao=0, no pedido_ok or pedido_erro.
